uart_rx_ctrl: RTL and testbench

Receive-side sequencer for the UART serial-in/parallel-out data register.
- Detects a start bit and times each bit from the oversampling tick.
- Issues one shift strobe per data bit, with the sampled bit value.
- Checks the stop bit, then captures the shift register's parallel word and flags completion or framing error to the host side.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_ctrl_if.sv | 34 +++
 rtl/sync_2ff.sv | 22 ++
 rtl/uart_rx_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive controller.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DATA_BITS_DEF  = 8;

  // Tick indices within a bit period for the default oversample rate.
  localparam int unsigned HALF_BIT_IDX = OVERSAMPLE_DEF / 2 - 1;
  localparam int unsigned FULL_BIT_IDX = OVERSAMPLE_DEF - 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  function automatic int unsigned half_bit_idx(input int unsigned oversample);
    return oversample / 2 - 1;
  endfunction

  function automatic int unsigned full_bit_idx(input int unsigned oversample);
    return oversample - 1;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Controller <-> shift register / host signals of the UART receiver.
// Carries parity_err only when UART_RX_PARITY_EN is defined.
interface uart_rx_ctrl_if #(
  parameter int unsigned DATA_BITS = uart_pkg::DATA_BITS_DEF
);
  logic                 shift_en;
  logic                 shift_din;
  logic [DATA_BITS-1:0] sipo_q;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 busy;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;

  modport master (
    output shift_en, shift_din, rx_data, rx_valid, frame_err, busy, parity_err,
    input  sipo_q
  );
  modport slave (
    input  shift_en, shift_din, rx_data, rx_valid, frame_err, busy, parity_err,
    output sipo_q
  );
`else
  modport master (
    output shift_en, shift_din, rx_data, rx_valid, frame_err, busy,
    input  sipo_q
  );
  modport slave (
    input  shift_en, shift_din, rx_data, rx_valid, frame_err, busy,
    output sipo_q
  );
`endif
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous level; resets to 1 (line idle).
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detect, per-bit shift strobes, stop check, word capture.
// Optional even-parity bit and parity_err output when UART_RX_PARITY_EN is defined.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tick,
  input  logic           rx,
  uart_rx_ctrl_if.master bus
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_BITS + 1);
  localparam logic [TickW-1:0] HalfIdx = TickW'(half_bit_idx(OVERSAMPLE));
  localparam logic [TickW-1:0] FullIdx = TickW'(full_bit_idx(OVERSAMPLE));
  localparam logic [BitW-1:0]  LastBit = BitW'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_e            state_q;
  logic [TickW-1:0]     tick_cnt_q;
  logic [BitW-1:0]      bit_cnt_q;
  logic                 break_q;
  logic                 shift_en_q;
  logic                 shift_din_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
`ifdef UART_RX_PARITY_EN
  logic                 parity_q;
  logic                 parity_bad_q;
  logic                 parity_err_q;
`endif

  sync_2ff u_sync_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      break_q      <= 1'b0;
      shift_en_q   <= 1'b0;
      shift_din_q  <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_q     <= 1'b0;
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      shift_en_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      // A break (stop sampled low) blocks new starts until the line returns high.
      if (rx_s) begin
        break_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (!rx_s && !break_q) begin
            state_q    <= StStart;
            tick_cnt_q <= '0;
          end
        end

        StStart: begin
          if (tick) begin
            if (tick_cnt_q == HalfIdx) begin
              tick_cnt_q <= '0;
              if (!rx_s) begin
                state_q   <= StData;
                bit_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                parity_q  <= 1'b0;
`endif
              end else begin
                state_q <= StIdle;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end

        StData: begin
          if (tick) begin
            if (tick_cnt_q == FullIdx) begin
              tick_cnt_q  <= '0;
              shift_en_q  <= 1'b1;
              shift_din_q <= rx_s;
              bit_cnt_q   <= bit_cnt_q + 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_q    <= parity_q ^ rx_s;
              if (bit_cnt_q == LastBit) begin
                state_q <= StParity;
              end
`else
              if (bit_cnt_q == LastBit) begin
                state_q <= StStop;
              end
`endif
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (tick) begin
            if (tick_cnt_q == FullIdx) begin
              tick_cnt_q   <= '0;
              parity_bad_q <= parity_q ^ rx_s;
              state_q      <= StStop;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
`endif

        StStop: begin
          if (tick) begin
            if (tick_cnt_q == FullIdx) begin
              tick_cnt_q <= '0;
              state_q    <= StIdle;
`ifdef UART_RX_PARITY_EN
              parity_err_q <= parity_bad_q;
              if (rx_s) begin
                if (!parity_bad_q) begin
                  rx_data_q  <= bus.sipo_q;
                  rx_valid_q <= 1'b1;
                end
              end else begin
                frame_err_q <= 1'b1;
                break_q     <= 1'b1;
              end
`else
              if (rx_s) begin
                rx_data_q  <= bus.sipo_q;
                rx_valid_q <= 1'b1;
              end else begin
                frame_err_q <= 1'b1;
                break_q     <= 1'b1;
              end
`endif
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.shift_en   = shift_en_q;
  assign bus.shift_din  = shift_din_q;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: directed frames, queue-based output checking.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int unsigned OS       = 16;
  localparam int unsigned DB       = 8;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned BIT_CLKS = OS * TICK_DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tick  = 1'b0;
  logic rx    = 1'b1;
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  uart_rx_ctrl_if #(.DATA_BITS(DB)) bus ();

  uart_rx_ctrl #(
    .OVERSAMPLE (OS),
    .DATA_BITS  (DB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .rx    (rx),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (TICK_DIV - 1) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end

  // Shift register model: LSB arrives first, so shift in at the MSB.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.sipo_q <= '0;
    else if (bus.shift_en) bus.sipo_q <= {bus.shift_din, bus.sipo_q[DB-1:1]};
  end

  typedef struct {
    int          kind;  // 0 rx_valid, 1 frame_err, 2 parity_err
    logic [7:0]  data;  // rx_data expected during the pulse
  } evt_t;

  evt_t exp_evt[$];
  logic exp_bits[$];
  int n_vec = 0, n_miss = 0;
  int n_shift = 0, n_valid = 0, n_ferr = 0, n_perr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_evt(input int kind, input logic [7:0] data);
    evt_t e;
    e.kind = kind;
    e.data = data;
    exp_evt.push_back(e);
  endtask

  task automatic check_evt(input int kind);
    evt_t e;
    chk("evt_expected", exp_evt.size() != 0, 1);
    if (exp_evt.size() != 0) begin
      e = exp_evt.pop_front();
      chk("evt_kind", kind, e.kind);
      chk("rx_data", bus.rx_data, e.data);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an output.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.shift_en) begin
        n_shift++;
        chk("shift_expected", exp_bits.size() != 0, 1);
        if (exp_bits.size() != 0) chk("shift_din", bus.shift_din, exp_bits.pop_front());
      end
      if (bus.rx_valid || bus.frame_err) chk("valid_ferr_excl", bus.rx_valid & bus.frame_err, 0);
      if (bus.rx_valid) begin
        n_valid++;
        check_evt(0);
      end
      if (bus.frame_err) begin
        n_ferr++;
        check_evt(1);
      end
`ifdef UART_RX_PARITY_EN
      if (bus.parity_err) begin
        n_perr++;
        check_evt(2);
      end
`endif
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_clks(BIT_CLKS);
  endtask

  // Leaves rx at the stop level; caller decides when the line returns high.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) begin
      exp_bits.push_back(d[i]);
      send_bit(d[i]);
    end
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`endif
    send_bit(stop);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_shift_en"}, bus.shift_en, 0);
    chk({tag, "_shift_din"}, bus.shift_din, 0);
    chk({tag, "_rx_data"}, bus.rx_data, 0);
    chk({tag, "_rx_valid"}, bus.rx_valid, 0);
    chk({tag, "_frame_err"}, bus.frame_err, 0);
    chk({tag, "_busy"}, bus.busy, 0);
`ifdef UART_RX_PARITY_EN
    chk({tag, "_parity_err"}, bus.parity_err, 0);
`endif
  endtask

  initial begin
    int s0, v0, f0;
    logic [7:0] part;

    rst_n = 1'b0;
    rx    = 1'b1;
    wait_clks(3);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    wait_clks(5);

    // Good frame 0xA5
    s0 = n_shift; v0 = n_valid;
    push_evt(0, 8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_clks(BIT_CLKS);
    chk("good_shift_cnt", n_shift - s0, 8);
    chk("good_valid_cnt", n_valid - v0, 1);
    chk("good_busy_idle", bus.busy, 0);
    chk("good_rx_data_held", bus.rx_data, 8'hA5);

    // Glitch start: low for 3 ticks only
    s0 = n_shift; v0 = n_valid;
    rx = 1'b0;
    wait_clks(3 * TICK_DIV);
    chk("glitch_busy_mid", bus.busy, 1);
    rx = 1'b1;
    wait_clks(BIT_CLKS);
    chk("glitch_busy_after", bus.busy, 0);
    chk("glitch_shift_cnt", n_shift - s0, 0);
    chk("glitch_valid_cnt", n_valid - v0, 0);

    // Framing error 0x3C, stop low, line held low (break)
    s0 = n_shift; v0 = n_valid; f0 = n_ferr;
    push_evt(1, 8'hA5);
    send_frame(8'h3C, 1'b0);
    wait_clks(BIT_CLKS);
    chk("break_busy_1", bus.busy, 0);
    wait_clks(BIT_CLKS);
    chk("break_busy_2", bus.busy, 0);
    chk("ferr_cnt", n_ferr - f0, 1);
    chk("ferr_valid_cnt", n_valid - v0, 0);
    chk("ferr_shift_cnt", n_shift - s0, 8);
    chk("ferr_rx_data_held", bus.rx_data, 8'hA5);
    rx = 1'b1;
    wait_clks(BIT_CLKS);
    push_evt(0, 8'h01);
    send_frame(8'h01, 1'b1);
    wait_clks(BIT_CLKS);
    chk("after_break_valid_cnt", n_valid - v0, 1);

    // Back-to-back 0xFF then 0x00
    s0 = n_shift; v0 = n_valid;
    push_evt(0, 8'hFF);
    push_evt(0, 8'h00);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h00, 1'b1);
    wait_clks(BIT_CLKS);
    chk("b2b_shift_cnt", n_shift - s0, 16);
    chk("b2b_valid_cnt", n_valid - v0, 2);

    // Reset after the 4th data bit
    s0 = n_shift;
    part = 8'hC3;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_bits.push_back(part[i]);
      send_bit(part[i]);
    end
    chk("midframe_busy", bus.busy, 1);
    chk("midframe_shift_cnt", n_shift - s0, 4);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    rx = 1'b1;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(5);
    s0 = n_shift; v0 = n_valid;
    push_evt(0, 8'h5A);
    send_frame(8'h5A, 1'b1);
    wait_clks(BIT_CLKS);
    chk("post_reset_shift_cnt", n_shift - s0, 8);
    chk("post_reset_valid_cnt", n_valid - v0, 1);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: parity bit 0 is wrong, 1 is right
    v0 = n_valid; f0 = n_perr;
    par_flip = 1'b1;
    push_evt(2, 8'h5A);
    send_frame(8'h07, 1'b1);
    wait_clks(BIT_CLKS);
    chk("par_bad_perr_cnt", n_perr - f0, 1);
    chk("par_bad_valid_cnt", n_valid - v0, 0);
    par_flip = 1'b0;
    push_evt(0, 8'h07);
    send_frame(8'h07, 1'b1);
    wait_clks(BIT_CLKS);
    chk("par_good_perr_cnt", n_perr - f0, 1);
    chk("par_good_valid_cnt", n_valid - v0, 1);
`endif

    chk("evt_queue_drained", exp_evt.size(), 0);
    chk("bit_queue_drained", exp_bits.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
